// File: rtl/vga_pixel_fetch.sv
// Read-side frame streamer: fetches packed pixel words from image RAM port 2,
// buffers them in a small word FIFO and hands out pixels in raster order over valid/ready.
module vga_pixel_fetch #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int PIX_W      = 8,
  parameter int H_PIX      = 640,
  parameter int V_PIX      = 400,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              underflow,
  input  logic              underflow_clr
);

  localparam int PPW    = DATA_W / PIX_W;
  localparam int NWORDS = H_PIX * V_PIX / PPW;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int IW     = $clog2(NWORDS + 1);
  localparam int SW     = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int XW     = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int YW     = (V_PIX > 1) ? $clog2(V_PIX) : 1;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [IW-1:0]     LAST_WORD = IW'(NWORDS - 1);
  localparam logic [SW-1:0]     LAST_SUB  = SW'(PPW - 1);
  localparam logic [XW-1:0]     LAST_X    = XW'(H_PIX - 1);
  localparam logic [YW-1:0]     LAST_Y    = YW'(V_PIX - 1);
  localparam logic [AW:0]       DEPTH_V   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            r_state, w_nextState;
  logic [ADDR_W-1:0] r_addr;
  logic [IW-1:0]     r_issued;
  logic              r_inFlight;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wrPtr, r_rdPtr;
  logic [AW:0]       r_count;
  logic [SW-1:0]     r_sub;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_underflow;

  logic [AW:0]       w_occupancy;
  logic              w_issue, w_valid, w_take, w_pop, w_push, w_lastPix, w_ufSet;
  logic [DATA_W-1:0] w_headWord;

  // Outstanding reads count against FIFO space so a returning word always has a slot.
  assign w_occupancy = r_count + {{AW{1'b0}}, r_inFlight};
  assign w_issue     = (r_state == FETCH) && (w_occupancy < DEPTH_V);
  assign w_valid     = (r_count != '0);
  assign w_take      = w_valid && pix_ready;
  assign w_pop       = w_take && (r_sub == LAST_SUB);
  assign w_push      = r_inFlight && !frame_start;
  assign w_lastPix   = w_take && (r_x == LAST_X) && (r_y == LAST_Y);
  assign w_ufSet     = (r_state != IDLE) && pix_ready && !w_valid && !frame_start;
  assign w_headWord  = r_mem[r_rdPtr];

  assign ram_address    = r_addr;
  assign ram_chipselect = w_issue;
  assign ram_clken      = 1'b1;
  assign pix_valid      = w_valid;
  assign pix_data       = w_valid ? w_headWord[int'(r_sub) * PIX_W +: PIX_W] : '0;
  assign pix_sof        = w_valid && (r_x == '0) && (r_y == '0);
  assign pix_eol        = w_valid && (r_x == LAST_X);
  assign underflow      = r_underflow;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (frame_start) w_nextState = FETCH;
      FETCH:   if (frame_start) w_nextState = FETCH;
               else if (w_issue && (r_issued == LAST_WORD)) w_nextState = DRAIN;
      DRAIN:   if (frame_start) w_nextState = FETCH;
               else if (w_lastPix) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= ram_readdata;
  end

  // A restart discards buffered words and the read still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= BASE;
      r_issued   <= '0;
      r_inFlight <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_sub      <= '0;
      r_x        <= '0;
      r_y        <= '0;
    end else if (frame_start) begin
      r_addr     <= BASE;
      r_issued   <= '0;
      r_inFlight <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_sub      <= '0;
      r_x        <= '0;
      r_y        <= '0;
    end else begin
      if (w_issue) begin
        r_addr   <= r_addr + 1'b1;
        r_issued <= r_issued + 1'b1;
      end
      r_inFlight <= w_issue;
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      if (w_take) begin
        r_sub <= (r_sub == LAST_SUB) ? '0 : r_sub + 1'b1;
        if (r_x == LAST_X) begin
          r_x <= '0;
          r_y <= (r_y == LAST_Y) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_underflow <= 1'b0;
    else if (w_ufSet)      r_underflow <= 1'b1;
    else if (underflow_clr) r_underflow <= 1'b0;
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: a small frame (8x2 pixels, 4-word FIFO) against a
// counting model of words issued, words buffered and pixel index.
module tb_vga_pixel_fetch;

  localparam int H    = 8;
  localparam int V    = 2;
  localparam int DEP  = 4;
  localparam int PPW  = 4;
  localparam int NW   = H * V / PPW;
  localparam int NPIX = H * V;
  localparam logic [17:0] BASE = 18'h100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start = 1'b0;
  logic [17:0] ram_address;
  logic        ram_chipselect;
  logic        ram_clken;
  logic [31:0] ram_readdata = 32'h0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [7:0]  pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        underflow;
  logic        underflow_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  vga_pixel_fetch #(
    .ADDR_W(18), .DATA_W(32), .PIX_W(8), .H_PIX(H), .V_PIX(V),
    .BASE_ADDR(32'h100), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  // RAM port 2: one-cycle read latency, word i holds pixels 4i..4i+3.
  always @(posedge clk) begin
    if (ram_chipselect)
      ram_readdata <= 32'h03020100 + 32'({14'd0, ram_address - BASE}) * 32'h04040404;
  end

  // Reference model: words issued, reads in flight, words buffered, pixel index.
  bit mActive = 1'b0;
  int mIssued = 0;
  bit mInflight = 1'b0;
  int mCount = 0;
  int mPidx = 0;
  bit mUf = 1'b0;
  bit eValid, eCs, eTake, ePop, eUfSet;

  always_comb begin
    eValid = (mCount > 0);
    eCs    = mActive && (mIssued < NW) && ((mCount + int'(mInflight)) < DEP);
    eTake  = eValid && pix_ready;
    ePop   = eTake && ((mPidx % PPW) == PPW - 1);
    eUfSet = mActive && pix_ready && !eValid && !frame_start;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mActive <= 1'b0; mIssued <= 0; mInflight <= 1'b0; mCount <= 0; mPidx <= 0; mUf <= 1'b0;
    end else if (frame_start) begin
      mActive <= 1'b1; mIssued <= 0; mInflight <= 1'b0; mCount <= 0; mPidx <= 0;
      if (underflow_clr) mUf <= 1'b0;
    end else begin
      mCount    <= mCount + int'(mInflight) - int'(ePop);
      mInflight <= eCs;
      if (eCs) mIssued <= mIssued + 1;
      if (eTake) begin
        if (mPidx == NPIX - 1) begin
          mActive <= 1'b0;
          mPidx   <= 0;
        end else begin
          mPidx <= mPidx + 1;
        end
      end
      if (eUfSet) mUf <= 1'b1;
      else if (underflow_clr) mUf <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("pix_valid", 32'(pix_valid), 32'(eValid));
    checkOutput("pix_data", 32'(pix_data), eValid ? 32'(mPidx % 256) : 32'h0);
    checkOutput("pix_sof", 32'(pix_sof), 32'(eValid && mPidx == 0));
    checkOutput("pix_eol", 32'(pix_eol), 32'(eValid && (mPidx % H) == H - 1));
    checkOutput("ram_chipselect", 32'(ram_chipselect), 32'(eCs));
    if (eCs) checkOutput("ram_address", 32'(ram_address), 32'(BASE) + 32'(mIssued));
    checkOutput("underflow", 32'(underflow), 32'(mUf));
    checkOutput("ram_clken", 32'(ram_clken), 32'h1);
  end

  // Logs of accepted pixels {sof,eol,data} and issued addresses for literal checks.
  logic [9:0]  acc[$];
  logic [17:0] addrs[$];

  always @(negedge clk) begin
    if (pix_valid && pix_ready) acc.push_back({pix_sof, pix_eol, pix_data});
    if (ram_chipselect) addrs.push_back(ram_address);
  end

  task automatic applyStimulus(input logic fs, input logic rdy, input logic clr);
    frame_start   = fs;
    pix_ready     = rdy;
    underflow_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic runFrame(input int readyPct, input int clrPct, input int restartPct);
    int n;
    n = 0;
    while (mActive && n < 3000) begin
      applyStimulus(int'($urandom_range(99)) < restartPct,
                    int'($urandom_range(99)) < readyPct,
                    int'($urandom_range(99)) < clrPct);
      n++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    if (mActive) begin
      checks++;
      errors++;
      $display("[TB] FAIL frameTimeout: frame still active after %0d cycles, expected done", n);
    end
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, " pixelCount"}, 32'(acc.size()), 32'd16);
    foreach (acc[i]) begin
      checkOutput({tag, " pixData"}, 32'(acc[i][7:0]), 32'(i));
      checkOutput({tag, " pixSof"}, 32'(acc[i][9]), 32'(i == 0));
      checkOutput({tag, " pixEol"}, 32'(acc[i][8]), 32'(i == 7 || i == 15));
    end
    checkOutput({tag, " readCount"}, 32'(addrs.size()), 32'd4);
    foreach (addrs[i]) checkOutput({tag, " readAddr"}, 32'(addrs[i]), 32'h100 + 32'(i));
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset pix_valid", 32'(pix_valid), 32'h0);
    checkOutput("reset chipselect", 32'(ram_chipselect), 32'h0);
    checkOutput("reset address", 32'(ram_address), 32'h100);
    checkOutput("reset pix_data", 32'(pix_data), 32'h0);
    checkOutput("reset sof/eol", 32'({pix_sof, pix_eol}), 32'h0);
    checkOutput("reset underflow", 32'(underflow), 32'h0);
    reset_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] basic frame");
    acc.delete(); addrs.delete();
    applyStimulus(1'b1, 1'b1, 1'b0);
    runFrame(100, 0, 0);
    checkFrame("basic");
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle chipselect", 32'(ram_chipselect), 32'h0);

    $display("[TB] backpressure");
    acc.delete(); addrs.delete();
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp readCount", 32'(addrs.size()), 32'd4);
    checkOutput("bp chipselect", 32'(ram_chipselect), 32'h0);
    checkOutput("bp pix_valid", 32'(pix_valid), 32'h1);
    checkOutput("bp pix_data", 32'(pix_data), 32'h0);
    runFrame(100, 0, 0);
    checkFrame("backpressure");

    $display("[TB] restart");
    applyStimulus(1'b1, 1'b1, 1'b0);
    n = 0;
    while (!(mPidx == 6 && mCount > 0) && n < 200) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      n++;
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    acc.delete(); addrs.delete();
    runFrame(100, 0, 0);
    checkFrame("restart");

    $display("[TB] underflow");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("uf cleared", 32'(underflow), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("uf set", 32'(underflow), 32'h1);
    runFrame(100, 0, 0);
    checkOutput("uf sticky", 32'(underflow), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("uf clr", 32'(underflow), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("uf set beats clr", 32'(underflow), 32'h1);
    runFrame(100, 0, 0);

    $display("[TB] async reset in drain");
    applyStimulus(1'b1, 1'b1, 1'b0);
    n = 0;
    while (!(mIssued == NW && mCount > 0) && n < 200) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      n++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst pix_valid", 32'(pix_valid), 32'h0);
    checkOutput("arst chipselect", 32'(ram_chipselect), 32'h0);
    checkOutput("arst underflow", 32'(underflow), 32'h0);
    checkOutput("arst address", 32'(ram_address), 32'h100);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post-reset idle chipselect", 32'(ram_chipselect), 32'h0);
    checkOutput("post-reset idle pix_valid", 32'(pix_valid), 32'h0);

    $display("[TB] random frames");
    for (int f = 0; f < 30; f++) begin
      applyStimulus(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
      runFrame(70, 10, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
